// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int DEFAULT_N_PORTS = 2;

    // Port IDs need at least one bit even for a single requester.
    function automatic int id_width(input int n_ports);
        return (n_ports > 1) ? $clog2(n_ports) : 1;
    endfunction

    typedef logic [id_width(DEFAULT_N_PORTS)-1:0] port_id_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// rtl/mem_arb_id_fifo.sv - in-order FIFO of issuing port IDs for outstanding transactions
module mem_arb_id_fifo #(
    parameter int ID_W  = 1,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [ID_W-1:0]  push_id,
    input  logic             pop,
    output logic [ID_W-1:0]  head_id,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [ID_W-1:0]  slots [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_id = slots[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge CLK) begin
        if (do_push) begin
            slots[wr_ptr_q] <= push_id;
        end
    end

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-port arbiter onto one in-order memory backend with lock, RR and timeout
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int        N_PORTS  = 2,
    parameter int        ADDR_W   = 32,
    parameter int        DATA_W   = 32,
    parameter int        MAX_OUT  = 4,
    parameter arb_mode_e ARB_MODE = ARB_FIXED,
    parameter int        TIMEOUT  = 1024
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [N_PORTS-1:0]            port_req_i,
    input  logic [N_PORTS-1:0]            port_we_i,
    input  logic [N_PORTS*ADDR_W-1:0]     port_addr_i,
    input  logic [N_PORTS*DATA_W-1:0]     port_wdata_i,
    input  logic [N_PORTS*DATA_W/8-1:0]   port_be_i,
    output logic [N_PORTS-1:0]            port_gnt_o,
    output logic [N_PORTS-1:0]            port_rvalid_o,
    output logic [DATA_W-1:0]             port_rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    output logic [DATA_W/8-1:0]           mem_be_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    output logic                          stall_o,
    output logic [$clog2(MAX_OUT+1)-1:0]  outstanding_o,
    output logic                          err_o
);

    localparam int ID_W  = id_width(N_PORTS);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic             lock_q;
    logic [ID_W-1:0]  lock_id_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [TW-1:0]    timer_q;
    logic             err_q;

    logic [ID_W-1:0]  low_id;
    logic [ID_W-1:0]  after_id;
    logic             has_after;
    logic [ID_W-1:0]  pick_id;
    logic [ID_W-1:0]  winner;
    logic             hs;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ID_W-1:0]  head_id;
    logic [CNT_W-1:0] count;

    // Downward scan leaves the lowest requester overall, and the lowest at/after rr_ptr.
    always_comb begin
        low_id    = '0;
        after_id  = '0;
        has_after = 1'b0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (port_req_i[k]) begin
                low_id = ID_W'(k);
                if (ID_W'(k) >= rr_ptr_q) begin
                    has_after = 1'b1;
                    after_id  = ID_W'(k);
                end
            end
        end
        if ((ARB_MODE == ARB_RR) && has_after) begin
            pick_id = after_id;
        end else begin
            pick_id = low_id;
        end
    end

    assign winner    = lock_q ? lock_id_q : pick_id;
    assign mem_req_o = (|port_req_i) & ~fifo_full;
    assign hs        = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & ~fifo_empty;

    always_comb begin
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_be_o      = '0;
        port_gnt_o    = '0;
        port_rvalid_o = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (mem_req_o && (winner == ID_W'(k))) begin
                mem_we_o      = port_we_i[k];
                mem_addr_o    = port_addr_i[k*ADDR_W +: ADDR_W];
                mem_wdata_o   = port_wdata_i[k*DATA_W +: DATA_W];
                mem_be_o      = port_be_i[k*BE_W +: BE_W];
                port_gnt_o[k] = mem_gnt_i;
            end
            if (pop && (head_id == ID_W'(k))) begin
                port_rvalid_o[k] = 1'b1;
            end
        end
    end

    assign port_rdata_o  = pop ? mem_rdata_i : '0;
    assign outstanding_o = count;
    assign err_o         = err_q;
    assign stall_o       = (|(port_req_i & ~port_gnt_o)) | ((count != '0) & ~mem_rvalid_i);

    mem_arb_id_fifo #(
        .ID_W  (ID_W),
        .DEPTH (MAX_OUT),
        .CNT_W (CNT_W)
    ) u_id_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (hs),
        .push_id (winner),
        .pop     (pop),
        .head_id (head_id),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            // A refused request freezes the winner so the backend sees a stable payload.
            if (hs) begin
                lock_q <= 1'b0;
            end else if (mem_req_o) begin
                lock_q    <= 1'b1;
                lock_id_q <= winner;
            end

            if (hs && (ARB_MODE == ARB_RR)) begin
                rr_ptr_q <= (winner == ID_W'(N_PORTS - 1)) ? '0 : winner + 1'b1;
            end

            if ((count == '0) || mem_rvalid_i) begin
                timer_q <= '0;
            end else if ((TIMEOUT != 0) && (timer_q != TMAX)) begin
                timer_q <= timer_q + 1'b1;
                if (timer_q == TLAST) begin
                    err_q <= 1'b1;
                end
            end

            if (mem_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter (fixed and round-robin instances)
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  port_req;
    logic [1:0]  port_we;
    logic [63:0] port_addr;
    logic [63:0] port_wdata;
    logic [7:0]  port_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic [1:0]  f_gnt, f_rvalid, r_gnt, r_rvalid;
    logic [31:0] f_rdata, r_rdata, f_maddr, r_maddr, f_mwdata, r_mwdata;
    logic        f_mreq, r_mreq, f_mwe, r_mwe, f_stall, r_stall, f_err, r_err;
    logic [3:0]  f_mbe, r_mbe;
    logic [2:0]  f_out, r_out;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUT(4),
                       .ARB_MODE(ARB_FIXED), .TIMEOUT(8)) dut_f (
        .CLK(CLK), .RST(RST),
        .port_req_i(port_req), .port_we_i(port_we), .port_addr_i(port_addr),
        .port_wdata_i(port_wdata), .port_be_i(port_be),
        .port_gnt_o(f_gnt), .port_rvalid_o(f_rvalid), .port_rdata_o(f_rdata),
        .mem_req_o(f_mreq), .mem_we_o(f_mwe), .mem_addr_o(f_maddr),
        .mem_wdata_o(f_mwdata), .mem_be_o(f_mbe),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .stall_o(f_stall), .outstanding_o(f_out), .err_o(f_err)
    );

    mem_port_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUT(4),
                       .ARB_MODE(ARB_RR), .TIMEOUT(8)) dut_r (
        .CLK(CLK), .RST(RST),
        .port_req_i(port_req), .port_we_i(port_we), .port_addr_i(port_addr),
        .port_wdata_i(port_wdata), .port_be_i(port_be),
        .port_gnt_o(r_gnt), .port_rvalid_o(r_rvalid), .port_rdata_o(r_rdata),
        .mem_req_o(r_mreq), .mem_we_o(r_mwe), .mem_addr_o(r_maddr),
        .mem_wdata_o(r_mwdata), .mem_be_o(r_mbe),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .stall_o(r_stall), .outstanding_o(r_out), .err_o(r_err)
    );

    typedef struct {
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic        e_mreq;
        logic [31:0] e_addr;
        logic        e_stall;
        logic [2:0]  e_out;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic [1:0] e_gnt, input logic [1:0] e_rv, input logic e_mreq,
                       input logic [31:0] e_addr, input logic e_stall, input logic [2:0] e_out);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_mreq = e_mreq; v.e_addr = e_addr;
        v.e_stall = e_stall; v.e_out = e_out;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rdata);
        port_req   = req;
        mem_gnt    = gnt;
        mem_rvalid = rv;
        mem_rdata  = rdata;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
    endtask

    logic [1:0] exp_rr [4];

    initial begin
        RST        = 1'b1;
        port_addr  = {A1, A0};
        port_we    = 2'b01;
        port_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        port_be    = 8'hFF;
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        exp_rr = '{2'b01, 2'b10, 2'b01, 2'b10};

        // single read on port 1, response three cycles later
        add(2'b10, 1, 0, 32'h0,         2'b10, 2'b00, 1, A1, 0, 0);
        add(2'b00, 1, 0, 32'h0,         2'b00, 2'b00, 0, 0,  1, 1);
        add(2'b00, 1, 0, 32'h0,         2'b00, 2'b00, 0, 0,  1, 1);
        add(2'b00, 1, 1, 32'hDEADBEEF,  2'b00, 2'b10, 0, 0,  0, 1);
        add(2'b00, 0, 0, 32'h0,         2'b00, 2'b00, 0, 0,  0, 0);
        // fixed priority: both request, port 0 first
        add(2'b11, 1, 0, 32'h0,         2'b01, 2'b00, 1, A0, 1, 0);
        add(2'b10, 1, 0, 32'h0,         2'b10, 2'b00, 1, A1, 1, 1);
        add(2'b00, 0, 1, 32'h0000_1111, 2'b00, 2'b01, 0, 0,  0, 2);
        add(2'b00, 0, 1, 32'h2222_3333, 2'b00, 2'b10, 0, 0,  0, 1);
        add(2'b00, 0, 0, 32'h0,         2'b00, 2'b00, 0, 0,  0, 0);
        // lock: port 1 refused twice while port 0 arrives
        add(2'b10, 0, 0, 32'h0,         2'b00, 2'b00, 1, A1, 1, 0);
        add(2'b11, 0, 0, 32'h0,         2'b00, 2'b00, 1, A1, 1, 0);
        add(2'b11, 1, 0, 32'h0,         2'b10, 2'b00, 1, A1, 1, 0);
        add(2'b01, 1, 0, 32'h0,         2'b01, 2'b00, 1, A0, 1, 1);
        add(2'b00, 0, 1, 32'h4444_5555, 2'b00, 2'b10, 0, 0,  0, 2);
        add(2'b00, 0, 1, 32'h6666_7777, 2'b00, 2'b01, 0, 0,  0, 1);
        add(2'b00, 0, 0, 32'h0,         2'b00, 2'b00, 0, 0,  0, 0);
        // fill to MAX_OUT, blocked issue alongside a pop, then drain in order
        add(2'b01, 1, 0, 32'h0,         2'b01, 2'b00, 1, A0, 0, 0);
        add(2'b10, 1, 0, 32'h0,         2'b10, 2'b00, 1, A1, 1, 1);
        add(2'b10, 1, 0, 32'h0,         2'b10, 2'b00, 1, A1, 1, 2);
        add(2'b01, 1, 0, 32'h0,         2'b01, 2'b00, 1, A0, 1, 3);
        add(2'b10, 1, 1, 32'h8888_0000, 2'b00, 2'b01, 0, 0,  1, 4);
        add(2'b10, 1, 0, 32'h0,         2'b10, 2'b00, 1, A1, 1, 3);
        add(2'b00, 0, 1, 32'h8888_0001, 2'b00, 2'b10, 0, 0,  0, 4);
        add(2'b00, 0, 1, 32'h8888_0002, 2'b00, 2'b10, 0, 0,  0, 3);
        add(2'b00, 0, 1, 32'h8888_0003, 2'b00, 2'b01, 0, 0,  0, 2);
        add(2'b00, 0, 1, 32'h8888_0004, 2'b00, 2'b10, 0, 0,  0, 1);
        add(2'b00, 0, 0, 32'h0,         2'b00, 2'b00, 0, 0,  0, 0);

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst.gnt",    {30'b0, f_gnt},    32'h0);
        chk("rst.rvalid", {30'b0, f_rvalid}, 32'h0);
        chk("rst.rdata",  f_rdata,           32'h0);
        chk("rst.mreq",   {31'b0, f_mreq},   32'h0);
        chk("rst.maddr",  f_maddr,           32'h0);
        chk("rst.stall",  {31'b0, f_stall},  32'h0);
        chk("rst.out",    {29'b0, f_out},    32'h0);
        chk("rst.err",    {31'b0, f_err},    32'h0);
        next_cycle();

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
            @(negedge CLK);
            chk($sformatf("v%0d.gnt", i),    {30'b0, f_gnt},    {30'b0, vecs[i].e_gnt});
            chk($sformatf("v%0d.rvalid", i), {30'b0, f_rvalid}, {30'b0, vecs[i].e_rv});
            chk($sformatf("v%0d.mreq", i),   {31'b0, f_mreq},   {31'b0, vecs[i].e_mreq});
            chk($sformatf("v%0d.stall", i),  {31'b0, f_stall},  {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d.out", i),    {29'b0, f_out},    {29'b0, vecs[i].e_out});
            chk($sformatf("v%0d.err", i),    {31'b0, f_err},    32'h0);
            if (vecs[i].e_mreq) begin
                chk($sformatf("v%0d.addr", i), f_maddr, vecs[i].e_addr);
            end
            if (vecs[i].e_rv != 2'b00) begin
                chk($sformatf("v%0d.rdata", i), f_rdata, vecs[i].rdata);
            end
            next_cycle();
        end

        // round-robin alternation with both ports held
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 1'b1, 1'b0, 32'h0);
            @(negedge CLK);
            chk($sformatf("rr%0d.gnt", k),    {30'b0, r_gnt}, {30'b0, exp_rr[k]});
            chk($sformatf("rr%0d.fixgnt", k), {30'b0, f_gnt}, 32'h1);
            next_cycle();
        end
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 1'b0, 1'b1, 32'h5A5A_0000 + k);
            @(negedge CLK);
            chk($sformatf("rr%0d.rvalid", k), {30'b0, r_rvalid}, {30'b0, exp_rr[k]});
            chk($sformatf("rr%0d.rdata", k),  r_rdata, 32'h5A5A_0000 + k);
            next_cycle();
        end

        // timeout after eight idle cycles, sticky, then reset and a stray response
        pulse_reset();
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        @(negedge CLK);
        chk("to.gnt", {30'b0, f_gnt}, 32'h2);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            chk($sformatf("to%0d.err", k), {31'b0, f_err}, (k >= 9) ? 32'h1 : 32'h0);
            next_cycle();
        end
        chk("to.out", {29'b0, f_out}, 32'h1);
        pulse_reset();
        @(negedge CLK);
        chk("to.rst_err", {31'b0, f_err}, 32'h0);
        chk("to.rst_out", {29'b0, f_out}, 32'h0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b1, 32'h1234_5678);
        @(negedge CLK);
        chk("stray.rvalid", {30'b0, f_rvalid}, 32'h0);
        next_cycle();
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk($sformatf("stray%0d.err", k), {31'b0, f_err}, 32'h1);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
